// File: rtl/clockwork_stream_pkg.sv
// Shared types and default sizes for the stencil stream source.
// Both the top and the buffer RAM import this package.
package clockwork_stream_pkg;
   localparam int SS_DATA_W_DEF = 16;
   localparam int SS_DEPTH_DEF  = 1024;
   localparam int SS_PASS_W_DEF = 16;

   typedef enum logic [2:0] {
      SS_IDLE,
      SS_LOAD,
      SS_PRIME,
      SS_RUN,
      SS_DONE
   } ss_state_t;
endpackage

// File: rtl/stream_buf_ram.sv
// Simple dual-port tile buffer: one write port and one synchronous read port.
// The read register is what the accelerator sees as read_data.
module stream_buf_ram
   import clockwork_stream_pkg::*;
#(
   parameter int DATA_W = SS_DATA_W_DEF,
   parameter int DEPTH  = SS_DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (re) rd_data_d = mem[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end

   assign q = rd_data_q;
endmodule

// File: rtl/stencil_stream_source.sv
// Host-loaded tile buffer that feeds an accelerator stencil read port,
// replaying the tile cfg_passes times at up to one word per cycle.
module stencil_stream_source
   import clockwork_stream_pkg::*;
#(
   parameter int DATA_W = SS_DATA_W_DEF,
   parameter int DEPTH  = SS_DEPTH_DEF,
   parameter int PASS_W = SS_PASS_W_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [AW:0]       cfg_len,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic              start,
   input  logic              host_wr_en,
   input  logic [DATA_W-1:0] host_wr_data,
   output logic              host_wr_ready,
   input  logic              read_en,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   output logic              busy,
   output logic              done,
   output logic              underflow
);
   localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

   ss_state_t         state_q, state_d;
   logic [AW:0]       len_q, len_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   logic [PASS_W-1:0] pass_q, pass_d, pass_inc;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d, rd_nxt;
   logic              underflow_q, underflow_d;
   logic              ram_we, ram_re;
   logic [AW-1:0]     ram_raddr;
   logic              cfg_ok, last_wr, last_rd;

   assign cfg_ok   = start && (cfg_len != '0) && (cfg_passes != '0);
   assign last_wr  = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));
   assign last_rd  = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));
   assign rd_nxt   = last_rd ? '0 : rd_ptr_q + AW'(1);
   assign pass_inc = pass_q + PASS_W'(1);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      passes_d    = passes_q;
      pass_d      = pass_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      underflow_d = underflow_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_raddr   = rd_ptr_q;

      case (state_q)
         SS_IDLE, SS_DONE: begin
            if (cfg_ok) begin
               state_d  = SS_LOAD;
               len_d    = cfg_len;
               passes_d = cfg_passes;
               wr_ptr_d = '0;
            end
         end
         SS_LOAD: begin
            if (host_wr_en) begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               if (last_wr) state_d = SS_PRIME;
            end
         end
         SS_PRIME: begin
            ram_re    = 1'b1;
            ram_raddr = '0;
            rd_ptr_d  = '0;
            pass_d    = '0;
            state_d   = SS_RUN;
         end
         SS_RUN: begin
            // Fetch the following word on every consume so read_data is
            // ready the next cycle; skip the fetch on the final word so it holds.
            if (read_en) begin
               rd_ptr_d  = rd_nxt;
               ram_re    = 1'b1;
               ram_raddr = rd_nxt;
               if (last_rd) begin
                  pass_d = pass_inc;
                  if (pass_inc == passes_q) begin
                     state_d = SS_DONE;
                     ram_re  = 1'b0;
                  end
               end
            end
         end
         default: state_d = SS_IDLE;
      endcase

      if (read_en && (state_q != SS_RUN)) underflow_d = 1'b1;

      if (flush) begin
         state_d     = SS_IDLE;
         pass_d      = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         underflow_d = 1'b0;
         ram_we      = 1'b0;
         ram_re      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SS_IDLE;
         len_q       <= '0;
         passes_q    <= '0;
         pass_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         passes_q    <= passes_d;
         pass_q      <= pass_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         underflow_q <= underflow_d;
      end
   end

   stream_buf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (host_wr_data),
      .re    (ram_re),
      .raddr (ram_raddr),
      .q     (read_data)
   );

   assign host_wr_ready = (state_q == SS_LOAD);
   assign read_valid    = (state_q == SS_RUN);
   assign busy          = (state_q != SS_IDLE);
   assign done          = (state_q == SS_DONE);
   assign underflow     = underflow_q;
endmodule

// File: tb/tb_stencil_stream_source.sv
// Randomized bench for stencil_stream_source: expected read stream is the
// loaded tile repeated passes times, consumed one word per read_en.
module tb_stencil_stream_source;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1024;
   localparam int PASS_W = 16;
   localparam int AW     = $clog2(DEPTH);

   logic              clk, rst, flush, start, host_wr_en, read_en;
   logic [AW:0]       cfg_len;
   logic [PASS_W-1:0] cfg_passes;
   logic [DATA_W-1:0] host_wr_data, read_data;
   logic              host_wr_ready, read_valid, busy, done, underflow;

   logic [DATA_W-1:0] tile_m [DEPTH];
   int total, bad;

   stencil_stream_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
      .start(start), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
      .host_wr_ready(host_wr_ready), .read_en(read_en), .read_data(read_data),
      .read_valid(read_valid), .busy(busy), .done(done), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_tile(input int len);
      for (int i = 0; i < len; i++) tile_m[i] = DATA_W'($urandom);
   endtask

   task automatic do_start(input int len, input int passes);
      cfg_len    = (AW+1)'(len);
      cfg_passes = PASS_W'(passes);
      start      = 1'b1;
      cyc();
      start      = 1'b0;
      cfg_len    = (AW+1)'($urandom);
      cfg_passes = PASS_W'($urandom);
   endtask

   task automatic load_tile(input int len);
      for (int i = 0; i < len; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            host_wr_en = 1'b0;
            cyc();
         end
         chk("ld_ready", 32'(host_wr_ready), 32'd1);
         host_wr_en   = 1'b1;
         host_wr_data = tile_m[i];
         cyc();
      end
      host_wr_en = 1'b0;
      chk("prime_busy", 32'(busy), 32'd1);
      chk("prime_valid", 32'(read_valid), 32'd0);
      chk("prime_ready", 32'(host_wr_ready), 32'd0);
      cyc();
   endtask

   // mode 0: read_en held, 1: toggled 1,0,1,0, 2: random
   task automatic run_model(input int len, input int passes, input int mode, input string tag);
      int consumed = 0;
      int total_w  = len * passes;
      int budget   = total_w * 4 + 20;
      int n        = 0;
      logic re;
      while (consumed < total_w && n < budget) begin
         chk({tag, "_valid"}, 32'(read_valid), 32'd1);
         chk({tag, "_data"}, 32'(read_data), 32'(tile_m[consumed % len]));
         chk({tag, "_done0"}, 32'(done), 32'd0);
         case (mode)
            0:       re = 1'b1;
            1:       re = (n % 2 == 0);
            default: re = 1'($urandom_range(0, 1));
         endcase
         read_en = re;
         cyc();
         n++;
         if (re) consumed++;
      end
      read_en = 1'b0;
      chk({tag, "_count"}, 32'(consumed), 32'(total_w));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_hold"}, 32'(read_data), 32'(tile_m[len-1]));
      chk({tag, "_valid_end"}, 32'(read_valid), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd1);
   endtask

   initial begin
      logic [DATA_W-1:0] held;
      total = 0; bad = 0;
      rst = 1'b1; flush = 1'b0; start = 1'b0; host_wr_en = 1'b0; read_en = 1'b0;
      cfg_len = '0; cfg_passes = '0; host_wr_data = '0;
      cyc(); cyc();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_data", 32'(read_data), 32'd0);
      chk("rst_valid", 32'(read_valid), 32'd0);
      chk("rst_ready", 32'(host_wr_ready), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      @(negedge clk) rst = 1'b0;
      cyc();

      // 1: fixed tile, read_en held
      for (int i = 0; i < 4; i++) tile_m[i] = DATA_W'(10 + i);
      do_start(4, 2);
      load_tile(4);
      run_model(4, 2, 0, "t1");

      // 2: same tile, toggled read_en, restarted from DONE
      do_start(4, 2);
      load_tile(4);
      run_model(4, 2, 1, "t2");

      // 3: underflow in IDLE and LOAD, then normal run, then flush clears it
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("t3_idle", 32'(busy), 32'd0);
      held = read_data;
      read_en = 1'b1; host_wr_en = 1'b1; host_wr_data = 16'hdead;
      cyc();
      read_en = 1'b0; host_wr_en = 1'b0;
      chk("t3_uf_idle", 32'(underflow), 32'd1);
      chk("t3_data_held", 32'(read_data), 32'(held));
      chk("t3_still_idle", 32'(busy), 32'd0);
      fill_tile(5);
      do_start(5, 2);
      read_en = 1'b1; cyc(); read_en = 1'b0;
      chk("t3_uf_load", 32'(underflow), 32'd1);
      chk("t3_in_load", 32'(host_wr_ready), 32'd1);
      load_tile(5);
      run_model(5, 2, 2, "t3");
      chk("t3_uf_sticky", 32'(underflow), 32'd1);
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("t3_uf_clr", 32'(underflow), 32'd0);

      // 4: flush mid-RUN (with read_en, flush wins), then len=2 restart
      fill_tile(4);
      do_start(4, 1);
      load_tile(4);
      read_en = 1'b1; cyc(); cyc();
      chk("t4_mid", 32'(read_data), 32'(tile_m[2]));
      flush = 1'b1; cyc(); flush = 1'b0; read_en = 1'b0;
      chk("t4_idle", 32'(busy), 32'd0);
      chk("t4_hold", 32'(read_data), 32'(tile_m[2]));
      chk("t4_uf", 32'(underflow), 32'd0);
      tile_m[0] = 16'd7; tile_m[1] = 16'd8;
      do_start(2, 1);
      load_tile(2);
      run_model(2, 1, 0, "t4");

      // 5: zero cfg ignored; full-depth tile
      flush = 1'b1; cyc(); flush = 1'b0;
      do_start(0, 1);
      chk("t5_len0", 32'(busy), 32'd0);
      do_start(3, 0);
      chk("t5_pass0", 32'(busy), 32'd0);
      chk("t5_pass0_rdy", 32'(host_wr_ready), 32'd0);
      fill_tile(DEPTH);
      do_start(DEPTH, 1);
      load_tile(DEPTH);
      run_model(DEPTH, 1, 2, "t5");

      // random tiles, replays and read patterns
      for (int k = 0; k < 6; k++) begin
         int l = $urandom_range(1, 24);
         int p = $urandom_range(1, 3);
         fill_tile(l);
         do_start(l, p);
         load_tile(l);
         run_model(l, p, 2, "rnd");
      end

      // 6: async reset mid-LOAD, between edges
      fill_tile(6);
      do_start(6, 1);
      for (int i = 0; i < 3; i++) begin
         host_wr_en = 1'b1; host_wr_data = tile_m[i]; cyc();
      end
      host_wr_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_ready", 32'(host_wr_ready), 32'd0);
      chk("t6_data", 32'(read_data), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_valid", 32'(read_valid), 32'd0);
      @(negedge clk) rst = 1'b0;
      cyc();
      chk("t6_after", 32'(busy), 32'd0);
      fill_tile(3);
      do_start(3, 2);
      load_tile(3);
      run_model(3, 2, 2, "t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
